// File: rtl/disp_arbiter.sv
// Round-robin owner of the shared 4-digit display word, with a minimum hold time
// per grant. States: IDLE | no owner, display frozen ; OWN | owner's data copied to segdata each cycle
module disp_arbiter #(
  parameter int unsigned HOLD  = 50000000,
  parameter int unsigned CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  output logic [2:0]  gnt,
  output logic [1:0]  owner,
  output logic        valid,
  output logic [15:0] segdata
);

  typedef enum logic {IDLE, OWN} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD - 1);

  state_t            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        gnt_q, gnt_d;
  logic [1:0]        owner_q, owner_d;
  logic              valid_q, valid_d;
  logic [15:0]       segdata_q, segdata_d;

  logic [15:0]       owner_data;
  logic [2:0]        other_req;
  logic              owner_req;
  logic              expired;
  logic [1:0]        next_idx;

  function automatic logic [1:0] inc3(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  function automatic logic [2:0] onehot3(input logic [1:0] i);
    return 3'b001 << i;
  endfunction

  // First requester at or after s in circular order; s is returned when nobody asks.
  function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] s);
    logic [1:0] i;
    i = s;
    for (int k = 0; k < 3; k++) begin
      if ((r & onehot3(i)) != 3'b000) return i;
      i = inc3(i);
    end
    return s;
  endfunction

  always_comb begin
    case (owner_q)
      2'd0:    owner_data = data0;
      2'd1:    owner_data = data1;
      default: owner_data = data2;
    endcase
  end

  assign owner_req = |(req & onehot3(owner_q));
  assign other_req = req & ~onehot3(owner_q);
  assign expired   = (cnt_q == CNT_MAX);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    valid_d   = valid_q;
    segdata_d = segdata_q;
    next_idx  = 2'd0;

    case (state_q)
      IDLE: begin
        if (|req) begin
          next_idx = pick(req, ptr_q);
          state_d  = OWN;
          gnt_d    = onehot3(next_idx);
          owner_d  = next_idx;
          cnt_d    = '0;
          ptr_d    = inc3(next_idx);
        end
      end
      default: begin
        segdata_d = owner_data;
        valid_d   = 1'b1;
        // A dropped request overrides the hold; otherwise only an expired hold yields.
        if ((|other_req) && (!owner_req || expired)) begin
          next_idx = pick(other_req, inc3(owner_q));
          gnt_d    = onehot3(next_idx);
          owner_d  = next_idx;
          cnt_d    = '0;
          ptr_d    = inc3(next_idx);
        end else if (!owner_req) begin
          state_d = IDLE;
          gnt_d   = 3'b000;
        end else if (!expired) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      cnt_q     <= '0;
      gnt_q     <= 3'b000;
      owner_q   <= 2'd0;
      valid_q   <= 1'b0;
      segdata_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      valid_q   <= valid_d;
      segdata_q <= segdata_d;
    end
  end

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign valid   = valid_q;
  assign segdata = segdata_q;

endmodule

// File: tb/tb_disp_arbiter.sv
// Bench for disp_arbiter: vector table with expected outputs (HOLD=4, plus a HOLD=1 copy),
// then a fairness sequence under full contention.
module tb_disp_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [15:0] data0, data1, data2;
  logic [2:0]  gnt, gnt1;
  logic [1:0]  owner, owner1;
  logic        valid, valid1;
  logic [15:0] segdata, segdata1;

  always #5 clk = ~clk;

  disp_arbiter #(.HOLD(4), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .req(req),
    .data0(data0), .data1(data1), .data2(data2),
    .gnt(gnt), .owner(owner), .valid(valid), .segdata(segdata)
  );

  disp_arbiter #(.HOLD(1), .CNT_W(8)) u_h1 (
    .clk(clk), .rst(rst), .req(req),
    .data0(data0), .data1(data1), .data2(data2),
    .gnt(gnt1), .owner(owner1), .valid(valid1), .segdata(segdata1)
  );

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic [15:0] d0, d1, d2;
    logic [2:0]  gnt;
    logic [1:0]  own;
    logic        vld;
    logic [15:0] seg;
    logic        chk1;
    logic [2:0]  gnt1;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic row(input logic r, input logic [2:0] rq,
                     input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                     input logic [2:0] g, input logic [1:0] o, input logic v,
                     input logic [15:0] s, input logic c1, input logic [2:0] g1);
    vec_t e;
    e.rst = r; e.req = rq; e.d0 = a; e.d1 = b; e.d2 = c;
    e.gnt = g; e.own = o; e.vld = v; e.seg = s; e.chk1 = c1; e.gnt1 = g1;
    vecs.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    vec_t v, e;
    int   cnt_own[3];

    rst = 1'b1; req = 3'b000; data0 = '0; data1 = '0; data2 = '0;

    // reset with req=111, then full contention
    row(1, 3'b111, 16'h0AAA, 16'h0BBB, 16'h0CCC, 3'b000, 0, 0, 16'h0000, 1, 3'b000);
    row(1, 3'b111, 16'h0AAA, 16'h0BBB, 16'h0CCC, 3'b000, 0, 0, 16'h0000, 1, 3'b000);
    row(0, 3'b111, 16'h0AAA, 16'h0BBB, 16'h0CCC, 3'b001, 0, 0, 16'h0000, 1, 3'b001);
    row(0, 3'b111, 16'h0AAA, 16'h0BBB, 16'h0CCC, 3'b001, 0, 1, 16'h0AAA, 1, 3'b010);
    row(0, 3'b111, 16'h0AAA, 16'h0BBB, 16'h0CCC, 3'b001, 0, 1, 16'h0AAA, 1, 3'b100);
    row(0, 3'b111, 16'h0AAA, 16'h0BBB, 16'h0CCC, 3'b001, 0, 1, 16'h0AAA, 1, 3'b001);
    row(0, 3'b111, 16'h0AAA, 16'h0BBB, 16'h0CCC, 3'b010, 1, 1, 16'h0AAA, 1, 3'b010);
    row(0, 3'b111, 16'h0AAA, 16'h0BBB, 16'h0CCC, 3'b010, 1, 1, 16'h0BBB, 0, 3'b000);
    row(0, 3'b111, 16'h0AAA, 16'h0BBB, 16'h0CCC, 3'b010, 1, 1, 16'h0BBB, 0, 3'b000);
    row(0, 3'b111, 16'h0AAA, 16'h0BBB, 16'h0CCC, 3'b010, 1, 1, 16'h0BBB, 0, 3'b000);
    row(0, 3'b111, 16'h0AAA, 16'h0BBB, 16'h0CCC, 3'b100, 2, 1, 16'h0BBB, 0, 3'b000);
    row(0, 3'b111, 16'h0AAA, 16'h0BBB, 16'h0CCC, 3'b100, 2, 1, 16'h0CCC, 0, 3'b000);
    row(0, 3'b111, 16'h0AAA, 16'h0BBB, 16'h0CCC, 3'b100, 2, 1, 16'h0CCC, 0, 3'b000);
    row(0, 3'b111, 16'h0AAA, 16'h0BBB, 16'h0CCC, 3'b100, 2, 1, 16'h0CCC, 0, 3'b000);
    row(0, 3'b111, 16'h0AAA, 16'h0BBB, 16'h0CCC, 3'b001, 0, 1, 16'h0CCC, 0, 3'b000);
    row(0, 3'b111, 16'h0AAA, 16'h0BBB, 16'h0CCC, 3'b001, 0, 1, 16'h0AAA, 0, 3'b000);
    // single requester, live data change, hold enforcement, early drops
    row(1, 3'b000, 16'h0AAA, 16'h0BBB, 16'h0CCC, 3'b000, 0, 0, 16'h0000, 0, 3'b000);
    row(0, 3'b001, 16'h1234, 16'h0BBB, 16'h0CCC, 3'b001, 0, 0, 16'h0000, 0, 3'b000);
    row(0, 3'b001, 16'h1234, 16'h0BBB, 16'h0CCC, 3'b001, 0, 1, 16'h1234, 0, 3'b000);
    row(0, 3'b011, 16'hBEEF, 16'h0BBB, 16'h0CCC, 3'b001, 0, 1, 16'hBEEF, 0, 3'b000);
    row(0, 3'b011, 16'hBEEF, 16'h0BBB, 16'h0CCC, 3'b001, 0, 1, 16'hBEEF, 0, 3'b000);
    row(0, 3'b011, 16'hBEEF, 16'h0BBB, 16'h0CCC, 3'b010, 1, 1, 16'hBEEF, 0, 3'b000);
    row(0, 3'b011, 16'hBEEF, 16'h0BBB, 16'h0CCC, 3'b010, 1, 1, 16'h0BBB, 0, 3'b000);
    row(0, 3'b001, 16'hBEEF, 16'h0BBB, 16'h0CCC, 3'b001, 0, 1, 16'h0BBB, 0, 3'b000);
    row(0, 3'b011, 16'hBEEF, 16'h0BBB, 16'h0CCC, 3'b001, 0, 1, 16'hBEEF, 0, 3'b000);
    row(0, 3'b010, 16'hBEEF, 16'h0BBB, 16'h0CCC, 3'b010, 1, 1, 16'hBEEF, 0, 3'b000);
    // owner 2 then idle freeze, re-grant from ptr 0
    row(0, 3'b100, 16'hBEEF, 16'h0BBB, 16'h5678, 3'b100, 2, 1, 16'h0BBB, 0, 3'b000);
    row(0, 3'b100, 16'hBEEF, 16'h0BBB, 16'h5678, 3'b100, 2, 1, 16'h5678, 0, 3'b000);
    row(0, 3'b000, 16'hBEEF, 16'h0BBB, 16'h5678, 3'b000, 2, 1, 16'h5678, 0, 3'b000);
    row(0, 3'b000, 16'hBEEF, 16'h0BBB, 16'h1111, 3'b000, 2, 1, 16'h5678, 0, 3'b000);
    row(0, 3'b011, 16'hBEEF, 16'h0BBB, 16'h1111, 3'b001, 0, 1, 16'h5678, 0, 3'b000);
    row(0, 3'b011, 16'hBEEF, 16'h0BBB, 16'h1111, 3'b001, 0, 1, 16'hBEEF, 0, 3'b000);
    // reset while owner 1 has cnt=2
    row(0, 3'b010, 16'hBEEF, 16'h0BBB, 16'h1111, 3'b010, 1, 1, 16'hBEEF, 0, 3'b000);
    row(0, 3'b010, 16'hBEEF, 16'h0BBB, 16'h1111, 3'b010, 1, 1, 16'h0BBB, 0, 3'b000);
    row(0, 3'b010, 16'hBEEF, 16'h0BBB, 16'h1111, 3'b010, 1, 1, 16'h0BBB, 0, 3'b000);
    row(1, 3'b110, 16'hBEEF, 16'h0BBB, 16'h1111, 3'b000, 0, 0, 16'h0000, 0, 3'b000);
    row(0, 3'b110, 16'hBEEF, 16'h0BBB, 16'h1111, 3'b010, 1, 0, 16'h0000, 0, 3'b000);
    row(0, 3'b110, 16'hBEEF, 16'h0BBB, 16'h1111, 3'b010, 1, 1, 16'h0BBB, 0, 3'b000);

    for (int k = 0; k < vecs.size(); k++) begin
      v = vecs[k];
      @(negedge clk);
      rst = v.rst; req = v.req; data0 = v.d0; data1 = v.d1; data2 = v.d2;
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check($sformatf("row%0d gnt", k + 1), 32'(gnt), 32'(e.gnt));
      check($sformatf("row%0d owner", k + 1), 32'(owner), 32'(e.own));
      check($sformatf("row%0d valid", k + 1), 32'(valid), 32'(e.vld));
      check($sformatf("row%0d segdata", k + 1), 32'(segdata), 32'(e.seg));
      if (e.chk1) check($sformatf("row%0d hold1 gnt", k + 1), 32'(gnt1), 32'(e.gnt1));
    end

    // fairness: 24 granted cycles from the first grant give 8 to each requester
    @(negedge clk); rst = 1'b1; req = 3'b111;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    cnt_own = '{0, 0, 0};
    for (int i = 0; i < 24; i++) begin
      check($sformatf("fair%0d onehot", i), 32'($onehot(gnt)), 32'd1);
      check($sformatf("fair%0d owner", i), 32'(gnt), 32'(3'b001 << owner));
      if (gnt == 3'b001) cnt_own[0]++;
      else if (gnt == 3'b010) cnt_own[1]++;
      else if (gnt == 3'b100) cnt_own[2]++;
      @(posedge clk); #1;
    end
    for (int r = 0; r < 3; r++) check($sformatf("fair share%0d", r), 32'(cnt_own[r]), 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
